// File: rtl/apb_master_if.sv
// Command/response handshake plus APB requester bus for apb_master.
// The master modport is the apb_master view; the slave modport is the
// view of whatever drives commands and models the APB completer.
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-command APB requester (IDLE -> SETUP -> ACCESS).
// One command in flight; a completion is reported with a one-cycle
// rsp_valid pulse. All outputs come straight from registers.
// Optional feature macro: APB_MASTER_TIMEOUT_EN -- aborts an ACCESS phase
// after TIMEOUT_CYCLES cycles without PREADY and reports rsp_err=1.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic          PCLK,
  input logic          PRESET,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] L_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t            r_state;
  state_t            w_state_next;

  logic              r_cmd_ready, w_cmd_ready;
  logic              r_psel, w_psel;
  logic              r_penable, w_penable;
  logic              r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic              r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;

`ifdef APB_MASTER_TIMEOUT_EN
  logic              r_rsp_err, w_rsp_err;
  logic [7:0]        r_cnt, w_cnt;
  logic [7:0]        w_cnt_inc;

  assign w_cnt_inc = r_cnt + 8'd1;
`else
  // Timeout limit only matters when the watchdog is built in.
  logic              w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^L_TIMEOUT;
`endif

  // State register.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and next register values for every output.
  always_comb begin
    w_state_next = r_state;
    w_pwrite     = r_pwrite;
    w_paddr      = r_paddr;
    w_pwdata     = r_pwdata;
    w_rsp_valid  = 1'b0;
    w_rsp_rdata  = r_rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
    w_rsp_err    = 1'b0;
    w_cnt        = r_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          w_state_next = S_SETUP;
          w_pwrite     = bus.cmd_write;
          w_paddr      = bus.cmd_addr;
          w_pwdata     = bus.cmd_wdata;
`ifdef APB_MASTER_TIMEOUT_EN
          w_cnt        = 8'd0;
`endif
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SETUP: begin
        w_state_next = S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.PREADY) begin
          // Completion: writes report zero data, reads capture PRDATA.
          w_state_next = S_IDLE;
          w_rsp_valid  = 1'b1;
          w_rsp_rdata  = r_pwrite ? '0 : bus.PRDATA;
        end else begin
`ifdef APB_MASTER_TIMEOUT_EN
          w_cnt = w_cnt_inc;
          if (w_cnt_inc >= L_TIMEOUT) begin
            w_state_next = S_IDLE;
            w_rsp_valid  = 1'b1;
            w_rsp_err    = 1'b1;
            w_rsp_rdata  = '0;
          end else begin
            w_state_next = S_ACCESS;
          end
`else
          w_state_next = S_ACCESS;
`endif
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    // Handshake/bus strobes follow the state being entered.
    w_cmd_ready = (w_state_next == S_IDLE);
    w_psel      = (w_state_next != S_IDLE);
    w_penable   = (w_state_next == S_ACCESS);
  end

  // Output registers.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cmd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_cmd_ready <= w_cmd_ready;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  // Wait-state counter and error flag of the ACCESS watchdog.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_cnt     <= 8'd0;
      r_rsp_err <= 1'b0;
    end else begin
      r_cnt     <= w_cnt;
      r_rsp_err <= w_rsp_err;
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Testbench for apb_master: directed scenarios plus randomized transfers
// checked against a transaction-level model (memory + latency arithmetic).
module tb_apb_master;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int L_TMO = 16;
`else
  localparam int L_TMO = 1000000;
`endif

  logic PCLK;
  logic PRESET;
  int   n_total;
  int   n_bad;

  logic [31:0] mem [logic [31:0]];

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_master #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .bus    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] slave_rd(input logic [31:0] addr);
    if (mem.exists(addr)) return mem[addr];
    return ~addr;
  endfunction

  // One command with a given number of PREADY-low ACCESS cycles.
  task automatic run_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input int waits);
    int          lat;
    int          acc;
    int          exp_lat;
    logic        to_exp;
    logic        done;
    logic [31:0] exp_rdata;
    to_exp    = (waits >= L_TMO);
    exp_lat   = to_exp ? (2 + L_TMO) : (3 + waits);
    exp_rdata = (wr || to_exp) ? 32'd0 : slave_rd(addr);
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = data;
    bus.PREADY    = 1'b0;
    bus.PRDATA    = $urandom;
    check("idle_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge PCLK);
    lat = 1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = $urandom;
    bus.cmd_wdata = $urandom;
    check("setup_psel", 32'(bus.PSEL), 32'd1);
    check("setup_penable", 32'(bus.PENABLE), 32'd0);
    check("setup_paddr", bus.PADDR, addr);
    check("setup_pwrite", 32'(bus.PWRITE), 32'(wr));
    check("setup_pwdata", bus.PWDATA, data);
    check("busy_ready", 32'(bus.cmd_ready), 32'd0);
    acc  = 0;
    done = 1'b0;
    while (!done && acc < 300) begin
      @(negedge PCLK);
      lat++;
      if (bus.PENABLE) begin
        acc++;
        check("access_psel", 32'(bus.PSEL), 32'd1);
        check("access_paddr", bus.PADDR, addr);
        check("access_pwrite", 32'(bus.PWRITE), 32'(wr));
        bus.PREADY = (acc > waits);
        bus.PRDATA = wr ? $urandom : slave_rd(addr);
      end else begin
        done = 1'b1;
      end
    end
    check("access_bound", 32'(done), 32'd1);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_latency", 32'(lat), 32'(exp_lat));
    check("rsp_psel", 32'(bus.PSEL), 32'd0);
    check("rsp_penable", 32'(bus.PENABLE), 32'd0);
    check("rsp_err", 32'(bus.rsp_err), 32'(to_exp));
    check("rsp_rdata", bus.rsp_rdata, exp_rdata);
    if (wr && !to_exp) mem[addr] = data;
    bus.PREADY = 1'b0;
    @(negedge PCLK);
    check("rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
    check("rsp_rdata_hold", bus.rsp_rdata, exp_rdata);
    check("rsp_ready_again", 32'(bus.cmd_ready), 32'd1);
  endtask

  // Three writes with cmd_valid held high and PREADY tied high.
  task automatic run_b2b();
    int          acc_at [3];
    int          k;
    int          nrsp;
    int          nlow;
    logic        took;
    logic [31:0] cur_addr;
    logic [31:0] cur_data;
    k        = 0;
    nrsp     = 0;
    nlow     = 0;
    cur_addr = 32'h0;
    cur_data = 32'hB0B0_0000;
    @(negedge PCLK);
    bus.PREADY    = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = cur_addr;
    bus.cmd_wdata = cur_data;
    for (int cyc = 0; cyc < 16; cyc++) begin
      took = 1'b0;
      if ((k == 1 || k == 2) && !bus.PSEL) nlow++;
      if (bus.rsp_valid) begin
        nrsp++;
        check("b2b_rsp_rdata", bus.rsp_rdata, 32'd0);
        check("b2b_rsp_err", 32'(bus.rsp_err), 32'd0);
      end
      if (k < 3 && bus.cmd_valid && bus.cmd_ready) begin
        acc_at[k]      = cyc;
        mem[cur_addr]  = cur_data;
        k++;
        took = 1'b1;
      end
      @(posedge PCLK);
      #1;
      if (took) begin
        if (k < 3) begin
          cur_addr      = 32'(4 * k);
          cur_data      = 32'hB0B0_0000 + 32'(k);
          bus.cmd_addr  = cur_addr;
          bus.cmd_wdata = cur_data;
        end else begin
          bus.cmd_valid = 1'b0;
        end
      end
      @(negedge PCLK);
    end
    check("b2b_accepts", 32'(k), 32'd3);
    if (k == 3) begin
      check("b2b_gap1", 32'(acc_at[1] - acc_at[0]), 32'd3);
      check("b2b_gap2", 32'(acc_at[2] - acc_at[1]), 32'd3);
    end
    check("b2b_rsp_count", 32'(nrsp), 32'd3);
    check("b2b_psel_low", 32'(nlow), 32'd2);
    bus.PREADY = 1'b0;
  endtask

  // Reset asserted in the middle of an ACCESS wait.
  task automatic run_reset_abort();
    int nrsp;
    nrsp = 0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h40;
    bus.cmd_wdata = 32'h0;
    bus.PREADY    = 1'b0;
    @(negedge PCLK);
    bus.cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_in_access", 32'(bus.PENABLE), 32'd1);
    PRESET = 1'b1;
    #1;
    check("rst_psel", 32'(bus.PSEL), 32'd0);
    check("rst_penable", 32'(bus.PENABLE), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_paddr", bus.PADDR, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    bus.PREADY = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      if (bus.rsp_valid) nrsp++;
    end
    check("rst_no_rsp", 32'(nrsp), 32'd0);
    check("rst_ready_after", 32'(bus.cmd_ready), 32'd1);
    bus.PREADY = 1'b0;
  endtask

  initial begin
    n_total       = 0;
    n_bad         = 0;
    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'd0;
    bus.cmd_wdata = 32'd0;
    bus.PRDATA    = 32'd0;
    bus.PREADY    = 1'b0;
    repeat (3) @(negedge PCLK);
    check("reset_psel", 32'(bus.PSEL), 32'd0);
    check("reset_penable", 32'(bus.PENABLE), 32'd0);
    check("reset_pwrite", 32'(bus.PWRITE), 32'd0);
    check("reset_paddr", bus.PADDR, 32'd0);
    check("reset_pwdata", bus.PWDATA, 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    PRESET = 1'b0;
    @(negedge PCLK);
    check("reset_ready", 32'(bus.cmd_ready), 32'd1);

    run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0);
    run_xfer(1'b0, 32'h10, 32'h0, 0);
    mem[32'h20] = 32'h12345678;
    run_xfer(1'b0, 32'h20, 32'h0, 4);
    run_b2b();
    run_xfer(1'b0, 32'h4, 32'h0, 1);
    run_xfer(1'b0, 32'h30, 32'h0, 100);
    run_xfer(1'b0, 32'h30, 32'h0, 15);
    run_xfer(1'b1, 32'h34, 32'h5A5A_0001, 16);
    run_reset_abort();

    for (int t = 0; t < 40; t++) begin
      logic        wr;
      logic [31:0] addr;
      int          waits;
      wr    = 1'($urandom_range(0, 1));
      addr  = 32'h100 + 32'(4 * $urandom_range(0, 7));
      waits = ($urandom_range(0, 9) == 0) ? int'($urandom_range(6, 20))
                                          : int'($urandom_range(0, 3));
      run_xfer(wr, addr, $urandom, waits);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter: ADDR_W, 32, width of cmd_addr/PADDR.
REQ-002 Parameter: DATA_W, 32, width of all data buses.
REQ-003 Parameter: TIMEOUT_CYCLES, 16, maximum ACCESS cycles without PREADY when APB_MASTER_TIMEOUT_EN is defined (range 1..255).
REQ-004 The block SHALL run on one clock; reset is asynchronous and active-high.
REQ-005 Port: PCLK  in  1  clock, all logic on rising edge.
REQ-006 Port: PRESET  in  1  asynchronous active-high reset.
REQ-007 Port: cmd_valid  in  1  command request.
REQ-008 Port: cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-009 Port: cmd_write  in  1  1 write, 0 read.
REQ-010 Port: cmd_addr  in  ADDR_W  transfer address.
REQ-011 Port: cmd_wdata  in  DATA_W  write data.
REQ-012 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-013 Port: rsp_rdata  out  DATA_W  read data, valid with rsp_valid.
REQ-014 Port: rsp_err  out  1  transfer aborted by timeout, valid with rsp_valid.
REQ-015 Ports: PSEL, PENABLE, PWRITE  out  1 each; PADDR  out  ADDR_W; PWDATA  out  DATA_W; PRDATA  in  DATA_W; PREADY  in  1 -- standard APB requester signals.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, ACCESS; all outputs registered.
REQ-017 IDLE: cmd_ready=1, PSEL=0, PENABLE=0; on cmd_valid, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA and go to SETUP.
REQ-018 cmd_ready SHALL be 0 in SETUP and ACCESS; cmd_valid there is ignored, not queued.
REQ-019 SETUP: PSEL=1, PENABLE=0 for exactly one cycle, then ACCESS.
REQ-020 ACCESS: PSEL=1, PENABLE=1; remain while PREADY=0 (wait states, unbounded unless REQ-029).
REQ-021 ACCESS with PREADY=1: next cycle PSEL=0, PENABLE=0, rsp_valid=1 for one cycle, state IDLE.
REQ-022 On read completion rsp_rdata SHALL take PRDATA sampled on the PREADY cycle; on write completion rsp_rdata SHALL be 0.
REQ-023 rsp_rdata SHALL hold its value until the next completion.
REQ-024 PADDR/PWRITE/PWDATA SHALL stay stable from SETUP through end of ACCESS and hold last values in IDLE.
REQ-025 Zero-wait-state transfer: cmd accept edge to rsp_valid = 3 cycles; back-to-back commands SHALL be accepted in the rsp_valid cycle (IDLE), giving 3 cycles per transfer.
REQ-026 rsp_err SHALL be 0 on every normal completion.

Reset
REQ-027 PRESET high SHALL immediately force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout counter 0; cmd_ready=1 after reset release.
REQ-028 Reset during SETUP or ACCESS SHALL abort the transfer with no rsp_valid.

Configuration
REQ-029 Macro APB_MASTER_TIMEOUT_EN defined: an 8-bit counter SHALL count ACCESS cycles with PREADY=0; upon reaching TIMEOUT_CYCLES the next cycle SHALL drive PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_rdata=0, state IDLE.
REQ-030 With the macro: PREADY=1 in the cycle the counter reaches its limit SHALL complete normally (rsp_err=0); counter clears on entry to SETUP.
REQ-031 Macro undefined: no counter, rsp_err SHALL be constant 0, ACCESS waits indefinitely.

Verification
REQ-032 Write, PREADY tied 1: cmd addr 0x10 data 0xDEADBEEF -> PSEL high 2 cycles, PENABLE high 1 cycle, rsp_valid 3 cycles after accept, rsp_rdata=0, rsp_err=0.
REQ-033 Read after write against APB slave model: read 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-034 Wait states: PREADY low 4 ACCESS cycles then high, PRDATA=0x12345678 -> PADDR/PWRITE stable throughout, rsp_valid 7 cycles after accept, rsp_rdata=0x12345678.
REQ-035 Back-to-back: cmd_valid held high for 3 writes (0x0,0x4,0x8) -> accepts every 3 cycles, three rsp_valid pulses, PSEL low one cycle between transfers.
REQ-036 Timeout (macro defined, TIMEOUT_CYCLES=16): PREADY held 0 -> rsp_valid with rsp_err=1, rsp_rdata=0, PSEL low; repeat with PREADY rising on 16th cycle -> rsp_err=0.
REQ-037 PRESET asserted mid-ACCESS -> PSEL/PENABLE low same cycle, no rsp_valid, cmd_ready=1 after release.
